// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_TX among NUM_REQ requesters.
// Optional ack watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int WORD_LENGHT = 8,
   parameter int NUM_REQ     = 4,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*WORD_LENGHT-1:0] req_data,
   output logic [NUM_REQ-1:0]             grant,
   output logic [WORD_LENGHT-1:0]         tx_data,
   output logic                           tx_send,
   input  logic                           tx_ready,
   output logic                           busy,
   output logic                           err_timeout
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || ACK_TIMEOUT < 1) begin : g_param_check
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and ACK_TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t                   state;
   state_t                   state_d;
   logic [PW-1:0]            ptr;
   logic [PW-1:0]            winner;
   logic [NUM_REQ-1:0]       win_onehot;
   logic [WORD_LENGHT-1:0]   win_data;
   logic                     launch;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   logic [CW-1:0] ack_cnt;
   logic          timeout_hit;
`endif

   // Winner: lowest set bit above the last grant, else lowest set bit overall (wrap).
   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      winner = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) winner = PW'(i);
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i] && (PW'(i) > ptr)) winner = PW'(i);
      end
   end

   always_comb begin
      win_onehot = '0;
      win_data   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == winner) begin
            win_onehot[i] = 1'b1;
            win_data      = req_data[i*WORD_LENGHT +: WORD_LENGHT];
         end
      end
   end

   always_comb begin
      state_d = state;
      launch  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (tx_ready && (|req)) begin
               launch  = 1'b1;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!tx_ready) begin
               state_d = WAIT_DONE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
               state_d     = IDLE;
               timeout_hit = 1'b1;
            end
`endif
         end
         WAIT_DONE: begin
            if (tx_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // tx_data is a plain holding register; it changes only on a launch.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         grant   <= '0;
         tx_send <= 1'b0;
         tx_data <= '0;
         ptr     <= PW'(NUM_REQ - 1);
      end else begin
         state   <= state_d;
         busy    <= (state_d != IDLE);
         tx_send <= launch;
         grant   <= launch ? win_onehot : '0;
         if (launch) begin
            tx_data <= win_data;
            ptr     <= winner;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   // Counts cycles spent in WAIT_ACK; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_cnt     <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state == WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
         else                   ack_cnt <= '0;
         if (timeout_hit) err_timeout <= 1'b1;
      end
   end
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX transmitter among NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's word and issues a one-cycle send pulse to the transmitter.
- Tracks the transmitter's Tx_ready handshake until the frame completes.
- Sits between on-chip data sources and UART_TX; drives UART_TX's Tx_in/send and observes its Tx_ready.

Parameters:
- WORD_LENGHT, 8: width of one transmitted word; must match the connected UART_TX.
- NUM_REQ, 4: number of requesters, 2..8.
- ACK_TIMEOUT, 8: cycles to wait for tx_ready to fall after a send pulse. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request per requester. Hold high with data stable until granted.
- req_data  in  NUM_REQ*WORD_LENGHT  word of requester i at bits [i*WORD_LENGHT +: WORD_LENGHT].
- grant  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- tx_data  out  WORD_LENGHT  to UART_TX Tx_in. Holds the latched word.
- tx_send  out  1  to UART_TX send. One-cycle pulse.
- tx_ready  in  1  from UART_TX Tx_ready. 1 = transmitter idle.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  sticky timeout flag. Constant 0 without UART_ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; grant=0; tx_send=0; tx_data=0; busy=0; err_timeout=0; last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer aborts immediately. A tx_send pulse in flight is dropped. The transmitter itself is not reset by this block.
- All outputs are registered.
- State machine:
  - IDLE: if tx_ready=1 and req!=0, pick the winner as the first set req bit searching from (pointer+1) mod NUM_REQ upward with wrap. At the next edge: grant[winner]=1, tx_data=req_data[winner], tx_send=1, pointer=winner, state->WAIT_ACK. If tx_ready=0 or req=0, stay in IDLE with no grant.
  - WAIT_ACK: grant and tx_send return to 0 (one-cycle pulses). If tx_ready=0, go to WAIT_DONE; otherwise stay.
  - WAIT_DONE: if tx_ready=1, go to IDLE.
- Latency: req sampled in IDLE -> grant and tx_send visible one cycle later.
- Back-to-back: the minimum gap between send pulses is frame time plus 2 cycles (WAIT_DONE->IDLE, then IDLE->launch).
- req is ignored outside IDLE. A requester must drop req the cycle after its grant, otherwise it is treated as a new request.
- Simultaneous requests: exactly one grant per arbitration. The winner becomes lowest priority for the next arbitration.
- tx_data holds its value until the next grant. It is never cleared except by reset.
- busy = (state != IDLE), registered with state.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK.
  - If tx_ready stays 1 for ACK_TIMEOUT cycles after the send pulse, state->IDLE and err_timeout is set to 1.
  - err_timeout stays 1 until reset. The arbiter keeps operating.
- Undefined: no counter; WAIT_ACK waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Single request: req=4'b0001 with word 8'h55 after reset release -> grant=4'b0001 and tx_send=1 one cycle later with tx_data=8'h55; busy stays high until tx_ready returns to 1.
- Simultaneous requests: req=4'b0101 held, words 8'hA1 and 8'hA3 -> first grant 4'b0001 (8'hA1), next grant 4'b0100 (8'hA3), never both.
- Fairness: all four requesters re-request after each grant -> grant order 0,1,2,3,0,...; 8 transfers give each requester exactly 2 grants.
- Request while busy: req[2] asserted during WAIT_DONE -> no grant until tx_ready=1 and the state is back in IDLE; then grant=4'b0100 with 8'h64.
- Reset mid-frame: rst=0 for 1 cycle during WAIT_DONE -> tx_send, grant and busy go to 0 asynchronously; after release, req[0] with 8'h10 is granted first.
- Timeout (with UART_ARB_TIMEOUT_EN, ACK_TIMEOUT=8): tx_ready held at 1 after a send pulse -> err_timeout=1 after 8 cycles, busy=0, and the next request is still granted.
